// File: rtl/sillyfunction_bist_if.sv
// Signal bundle between the sillyfunction BIST controller and its surroundings:
// system control (start/abort/status) plus the drive/observe pins of the block under test.
interface sillyfunction_bist_if;
  logic       start;
  logic       abort;
  logic       y;
  logic       a;
  logic       b;
  logic       c;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] err_count;
  logic [2:0] first_fail;
  logic       first_fail_valid;

  modport master (
    input  start, abort, y,
    output a, b, c, busy, done, pass, err_count, first_fail, first_fail_valid
  );

  modport slave (
    output start, abort, y,
    input  a, b, c, busy, done, pass, err_count, first_fail, first_fail_valid
  );
endinterface

// File: rtl/sillyfunction_bist.sv
// BIST controller for the 3-input sillyfunction block: walks {a,b,c} through all
// eight vectors, samples y after SETTLE cycles and scores it against GOLDEN.
module sillyfunction_bist #(
  parameter int unsigned SETTLE = 2,
  parameter logic [7:0]  GOLDEN = 8'h31
) (
  input  logic                 clk,
  input  logic                 reset_n,
  sillyfunction_bist_if.master bus
);

  localparam logic [3:0] SETTLE_M1 = 4'(SETTLE - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e     r_state;
  state_e     w_next;
  logic [2:0] r_vec;
  logic [3:0] r_cnt;
  logic [3:0] r_err;
  logic [2:0] r_first_fail;
  logic       r_first_fail_valid;
  logic [2:0] r_abc;
  logic       r_done;
  logic       w_sample;
  logic       w_last;
  logic       w_miss;

  assign w_sample = (r_state == S_RUN) && (r_cnt == SETTLE_M1);
  assign w_last   = w_sample && (r_vec == 3'd7);

  // An unknown y fails the equality test and falls through to the mismatch default.
  always_comb begin
    w_miss = 1'b1;
    if (bus.y == GOLDEN[r_vec]) w_miss = 1'b0;
  end

  // NOTE: state and datapath registers use non-blocking assignments so every
  // flop samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // NOTE: combinational blocks assign a default first so no path leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next = r_state;
    if (bus.abort) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (bus.start) w_next = S_RUN;
        S_RUN:   if (w_last)    w_next = S_DONE;
        S_DONE:  if (bus.start) w_next = S_RUN;
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_vec              <= '0;
      r_cnt              <= '0;
      r_err              <= '0;
      r_first_fail       <= '0;
      r_first_fail_valid <= 1'b0;
      r_abc              <= '0;
      r_done             <= 1'b0;
    end else if (bus.abort) begin
      r_vec              <= '0;
      r_cnt              <= '0;
      r_err              <= '0;
      r_first_fail       <= '0;
      r_first_fail_valid <= 1'b0;
      r_abc              <= '0;
      r_done             <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            r_vec              <= '0;
            r_cnt              <= '0;
            r_err              <= '0;
            r_first_fail       <= '0;
            r_first_fail_valid <= 1'b0;
            r_abc              <= '0;
          end
        end
        S_RUN: begin
          if (w_sample) begin
            if (w_miss) begin
              r_err <= r_err + 4'd1;
              if (!r_first_fail_valid) begin
                r_first_fail       <= r_vec;
                r_first_fail_valid <= 1'b1;
              end
            end
            r_cnt <= '0;
            if (w_last) begin
              r_abc  <= '0;
              r_done <= 1'b1;
            end else begin
              r_vec <= r_vec + 3'd1;
              r_abc <= r_vec + 3'd1;
            end
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.busy             = (r_state == S_RUN);
    bus.pass             = (r_state == S_DONE) && (r_err == 4'd0);
    bus.done             = r_done;
    bus.err_count        = r_err;
    bus.first_fail       = r_first_fail;
    bus.first_fail_valid = r_first_fail_valid;
    bus.a                = r_abc[2];
    bus.b                = r_abc[1];
    bus.c                = r_abc[0];
  end

endmodule

// File: doc/sillyfunction_bist.md
# sillyfunction_bist

Built-in self-test controller for the 3-input `sillyfunction` combinational block. It sequences all eight input vectors {a,b,c} = 000…111 into the block and samples `y` after a programmable settle time. Each sample is compared against a golden truth table, and the controller reports pass/fail, an error count and the first failing vector. It sits beside the `sillyfunction` instance, owns its inputs while busy, and is started by a one-cycle `start` pulse from system control.

## Interface
- `SETTLE`, 2: cycles each vector is held before `y` is sampled; legal range 1–15.
- `GOLDEN`, 8'h31: expected `y` per vector; bit i is the expected `y` for {a,b,c} = i (000→1, 100→1, 101→1, others 0).
- `clk`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a test run; honoured only in IDLE or DONE.
- `abort`  in  1  terminate the run; return to IDLE.
- `a`, `b`, `c`  out  1 each  registered drive to `sillyfunction`.
- `y`  in  1  `sillyfunction` output.
- `busy`  out  1  high while in RUN.
- `done`  out  1  one-cycle pulse on the RUN→DONE transition.
- `pass`  out  1  valid in DONE; high if `err_count` == 0.
- `err_count`  out  4  mismatches in the last completed run (0–8).
- `first_fail`  out  3  index {a,b,c} of the first mismatching vector.
- `first_fail_valid`  out  1  high once any mismatch has been recorded in the current run.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE→RUN on `start`.
  - RUN→DONE after vector 7 is sampled.
  - DONE→RUN on `start`.
  - Any state→IDLE on `abort`. `abort` has priority over `start` and over completion.
- Registers:
  - 3-bit vector index `vec`.
  - 4-bit settle counter `cnt`, counting 0..SETTLE-1.
  - `err_count`, `first_fail`, `first_fail_valid`.
- Entering RUN:
  - `vec`, `cnt`, `err_count`, `first_fail` and `first_fail_valid` clear to 0.
  - `{a,b,c}` = 000.
- In RUN:
  - `cnt` increments every cycle.
  - On the cycle with `cnt` == SETTLE-1, `y` is compared with `GOLDEN[vec]`.
  - A mismatch increments `err_count`.
  - On the first mismatch only, `first_fail` is set to `vec` and `first_fail_valid` is set high.
  - A `y` value that is not 0/1 (X/Z in simulation) counts as a mismatch.
  - On the same edge, `vec` increments, `cnt` resets to 0, and `{a,b,c}` takes the new `vec`.
  - When the sampled vector is 7, the FSM goes to DONE instead, `{a,b,c}` returns to 000, and `done` pulses.
- DONE: results are held stable until the next `start` or `abort`.
- `start` during RUN is ignored.
- `abort`:
  - `{a,b,c}` go to 000.
  - `pass` = 0.
  - `err_count`, `first_fail` and `first_fail_valid` clear.
  - No `done` pulse.
- `pass` = (state == DONE) && (`err_count` == 0). It is 0 in IDLE and RUN.

## Timing
- Reset (async, `reset_n` low): state = IDLE, and every output is 0: `a`, `b`, `c`, `busy`, `done`, `pass`, `err_count`, `first_fail`, `first_fail_valid`.
- `start` sampled high at edge E0 → `busy` = 1 and `{a,b,c}` = 000 after E0.
- Vector i is driven after edge E0 + i·SETTLE and sampled at edge E0 + (i+1)·SETTLE.
- `done` is high for exactly the one cycle after edge E0 + 8·SETTLE. On that same edge `busy` falls and `pass`/`err_count` become valid.
- Total latency from start to done: 8·SETTLE cycles. With SETTLE = 2 this is 16 cycles.
- `start` asserted in the `done` cycle restarts immediately. Results clear on the next edge.
- `abort` and `start` asserted together: the FSM goes to IDLE.
- `reset_n` asserted mid-run: immediate return to the reset values, with no `done` pulse.

## Test plan
- Correct `sillyfunction` attached, SETTLE = 2, pulse `start` → `{a,b,c}` steps 000..111 every 2 cycles; `done` pulses 16 cycles after start; `pass` = 1, `err_count` = 0, `first_fail_valid` = 0.
- `y` forced to 0 → mismatches on vectors 0, 4 and 5; `err_count` = 3, `first_fail` = 0, `first_fail_valid` = 1, `pass` = 0.
- `y` forced to 1 → `err_count` = 5, `first_fail` = 1, `pass` = 0.
- `abort` pulsed 5 cycles into a run → next cycle state IDLE: `busy` = 0, `{a,b,c}` = 000, `err_count` = 0, no `done` pulse. A subsequent `start` completes normally with `pass` = 1.
- `start` re-pulsed while `busy` → ignored; `done` still arrives exactly 16 cycles after the original start.
- `reset_n` dropped asynchronously between clock edges mid-run → all outputs are 0 immediately; after release, IDLE is held until `start`.
